instr_loader: RTL

- Program loader that fills the Bitty instruction memory before the core runs.
- Accepts a byte stream over a valid/ready handshake, normally from a UART receiver.
- Assembles big-endian 16-bit instruction words and writes them to consecutive addresses from 0.
- Holds the fetch unit (PC, branch logic) in hold until the load completes successfully.

---
 rtl/bitty_loader_pkg.sv | 34 +++
 rtl/loader_timeout.sv | 38 +++
 rtl/instr_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bitty_loader_pkg.sv
// Shared definitions for the Bitty instruction loader: state encoding and count-byte decoding.
package bitty_loader_pkg;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LEN   = 3'd1;
   localparam logic [2:0] HI    = 3'd2;
   localparam logic [2:0] LO    = 3'd3;
   localparam logic [2:0] WRITE = 3'd4;
   localparam logic [2:0] CHK   = 3'd5;
   localparam logic [2:0] DONE  = 3'd6;
   localparam logic [2:0] ERR   = 3'd7;

   localparam int unsigned COUNT_ZERO_MEANS_MAX = 256;

   typedef enum logic [2:0] {
      StIdle  = IDLE,
      StLen   = LEN,
      StHi    = HI,
      StLo    = LO,
      StWrite = WRITE,
      StChk   = CHK,
      StDone  = DONE,
      StErr   = ERR
   } state_e;

   // A count byte of zero stands for a full 256-word image.
   function automatic logic [8:0] word_count(input logic [7:0] count_byte);
      if (count_byte == 8'h00) begin
         return 9'(COUNT_ZERO_MEANS_MAX);
      end
      return {1'b0, count_byte};
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for the loader: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT. TIMEOUT of 0 disables it.
module loader_timeout #(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_hit
);

   localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   generate
      if (TIMEOUT == 0) begin : g_off
         logic w_unused;
         assign w_unused = ^{clk, reset, i_clr, i_en};
         assign o_hit    = 1'b0;
      end else begin : g_on
         logic [CntW-1:0] r_count;

         always_ff @(posedge clk) begin
            if (reset) begin
               r_count <= '0;
            end else if (i_clr) begin
               r_count <= '0;
            end else if (i_en) begin
               r_count <= r_count + 1'b1;
            end
         end

         // Fires on the increment that lands on TIMEOUT so the abort is taken on that same edge.
         assign o_hit = i_en & ~i_clr & (r_count == CntW'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/instr_loader.sv
// Bitty program loader: takes a count byte plus big-endian word bytes, writes instruction memory
// from address 0 and holds the core until done. Define INSTR_LOADER_CHECKSUM_EN for XOR check byte.
module instr_loader
   import bitty_loader_pkg::*;
#(
   parameter int unsigned TIMEOUT = 65535,
   parameter int unsigned ADDR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   state_e            r_state;
   state_e            w_state_d;
   logic              r_rx_ready;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [15:0]       r_mem_wdata;
   logic [7:0]        r_hi;
   logic [8:0]        r_remaining;

   logic w_xfer;
   logic w_start_ok;
   logic w_tmo_en;
   logic w_tmo_hit;
   logic w_last_word;

   assign w_xfer      = rx_valid & r_rx_ready;
   assign w_start_ok  = start & (r_state inside {StIdle, StDone, StErr});
   assign w_tmo_en    = r_state inside {StLen, StHi, StLo, StChk};
   assign w_last_word = (r_remaining == 9'd1);

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0] r_xor;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_xor <= 8'h00;
      end else if (w_start_ok) begin
         r_xor <= 8'h00;
      end else if (w_xfer && r_state != StChk) begin
         r_xor <= r_xor ^ rx_data;
      end
   end
`endif

   loader_timeout #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk  (clk),
      .reset(reset),
      .i_clr(w_xfer | w_start_ok),
      .i_en (w_tmo_en),
      .o_hit(w_tmo_hit)
   );

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (start) w_state_d = StLen;
         end
         StLen: begin
            if (w_tmo_hit)   w_state_d = StErr;
            else if (w_xfer) w_state_d = StHi;
         end
         StHi: begin
            if (w_tmo_hit)   w_state_d = StErr;
            else if (w_xfer) w_state_d = StLo;
         end
         StLo: begin
            if (w_tmo_hit)   w_state_d = StErr;
            else if (w_xfer) w_state_d = StWrite;
         end
         StWrite: begin
            if (w_last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
               w_state_d = StChk;
`else
               w_state_d = StDone;
`endif
            end else begin
               w_state_d = StHi;
            end
         end
         StChk: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (w_tmo_hit)   w_state_d = StErr;
            else if (w_xfer) w_state_d = (rx_data == r_xor) ? StDone : StErr;
`else
            w_state_d = StIdle;
`endif
         end
         StDone, StErr: begin
            if (start) w_state_d = StLen;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= StIdle;
         r_rx_ready  <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 16'h0000;
         r_hi        <= 8'h00;
         r_remaining <= 9'd0;
      end else begin
         r_state    <= w_state_d;
         // Registered from the next state so ready drops on the same edge as an abort.
         r_rx_ready <= w_state_d inside {StLen, StHi, StLo, StChk};
         if (w_start_ok) begin
            r_mem_addr <= '0;
         end
         if (r_state == StLen && w_xfer) begin
            r_remaining <= word_count(rx_data);
         end
         if (r_state == StHi && w_xfer) begin
            r_hi <= rx_data;
         end
         if (r_state == StLo && w_xfer) begin
            r_mem_wdata <= {r_hi, rx_data};
         end
         if (r_state == StWrite) begin
            r_mem_addr  <= r_mem_addr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
         end
      end
   end

   assign rx_ready  = r_rx_ready;
   assign mem_we    = (r_state == StWrite);
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign done      = (r_state == StDone);
   assign error     = (r_state == StErr);
   assign cpu_hold  = (r_state != StDone);

endmodule
